// File: rtl/clock_tick_gen.sv
// Timebase divider: periodic one-cycle tick, square wave sq and double-rate half pulse.
// Define TICK_GEN_FRAC_EN for the fractional phase-accumulator mode; the default is integer mode.
module clock_tick_gen #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 1,
  parameter int FAST_MUL = 8,
  parameter int CNT_W    = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic fast,
  output logic tick,
  output logic sq,
  output logic half
);

`ifdef TICK_GEN_FRAC_EN
  localparam longint M_I = longint'(CLK_HZ);
  localparam longint B_I = longint'(TICK_HZ);
`else
  localparam longint M_I = longint'(CLK_HZ / TICK_HZ);
  localparam longint B_I = 64'sd1;
`endif
  localparam longint HI_I = (M_I + 64'sd1) / 64'sd2;

  localparam logic [CNT_W-1:0] M_V         = CNT_W'(M_I);
  localparam logic [CNT_W-1:0] HI_V        = CNT_W'(HI_I);
  localparam logic [CNT_W-1:0] STEP_NORMAL = CNT_W'(B_I);
  localparam logic [CNT_W-1:0] STEP_FAST   = CNT_W'(B_I * longint'(FAST_MUL));

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] step;
  logic [CNT_W-1:0] nxt;
  logic [CNT_W-1:0] cnt_new;
  logic             wrap;
  logic             cross_hi;

  always_comb begin
    step     = fast ? STEP_FAST : STEP_NORMAL;
    nxt      = cnt + step;
    wrap     = (nxt >= M_V);
    cross_hi = (cnt < HI_V) && (nxt >= HI_V);
`ifdef TICK_GEN_FRAC_EN
    // Keep the remainder so the long-run rate is exact.
    cnt_new  = wrap ? (nxt - M_V) : nxt;
`else
    cnt_new  = wrap ? '0 : nxt;
`endif
  end

  // Clear shares reset's values, so a clear on the wrap edge suppresses the tick.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      tick <= 1'b0;
      half <= 1'b0;
      sq   <= 1'b1;
    end else if (en) begin
      cnt  <= cnt_new;
      tick <= wrap;
      half <= wrap || cross_hi;
      sq   <= (cnt_new < HI_V);
    end else begin
      tick <= 1'b0;
      half <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clock_tick_gen.sv
// Bench for clock_tick_gen: vector table on a 10:1 divider, hand sequences for the odd
// and fractional divisors, and randomized inputs against a reference model on three instances.
module tb_clock_tick_gen;

  logic clk = 1'b0;
  logic rst, en, clr, fast;
  logic ta, sa, ha, tb_, sb, hb, tc, sc, hc;
  logic [2:0] dut_out [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  clock_tick_gen #(.CLK_HZ(10), .TICK_HZ(1), .FAST_MUL(4), .CNT_W(32)) u_a (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .fast(fast), .tick(ta), .sq(sa), .half(ha));
  clock_tick_gen #(.CLK_HZ(7), .TICK_HZ(1), .FAST_MUL(3), .CNT_W(32)) u_b (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .fast(fast), .tick(tb_), .sq(sb), .half(hb));
  clock_tick_gen #(.CLK_HZ(10), .TICK_HZ(3), .FAST_MUL(2), .CNT_W(32)) u_c (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .fast(fast), .tick(tc), .sq(sc), .half(hc));

  assign dut_out[0] = {ta, sa, ha};
  assign dut_out[1] = {tb_, sb, hb};
  assign dut_out[2] = {tc, sc, hc};

  // Reference model: phase in [0, M), advanced by the step, outputs derived from the phase.
  int   m_m [3];
  int   m_b [3];
  int   m_mul [3];
  int   m_cnt [3];
  logic m_tick [3];
  logic m_sq [3];
  logic m_half [3];

  function automatic void model_cfg(int i, int clk_hz, int tick_hz, int mul);
`ifdef TICK_GEN_FRAC_EN
    m_m[i] = clk_hz;
    m_b[i] = tick_hz;
`else
    m_m[i] = clk_hz / tick_hz;
    m_b[i] = 1;
`endif
    m_mul[i]  = mul;
    m_cnt[i]  = 0;
    m_tick[i] = 1'b0;
    m_half[i] = 1'b0;
    m_sq[i]   = 1'b1;
  endfunction

  function automatic void model_edge(logic r, logic e, logic c, logic f);
    for (int i = 0; i < 3; i++) begin
      int hi, s, n;
      hi = (m_m[i] + 1) / 2;
      if (r || c) begin
        m_cnt[i] = 0; m_tick[i] = 1'b0; m_half[i] = 1'b0; m_sq[i] = 1'b1;
      end else if (e) begin
        s = f ? m_b[i] * m_mul[i] : m_b[i];
        n = m_cnt[i] + s;
        if (n >= m_m[i]) begin
          m_tick[i] = 1'b1;
          m_half[i] = 1'b1;
`ifdef TICK_GEN_FRAC_EN
          m_cnt[i] = n % m_m[i];
`else
          m_cnt[i] = 0;
`endif
        end else begin
          m_tick[i] = 1'b0;
          m_half[i] = (m_cnt[i] < hi) && (n >= hi);
          m_cnt[i] = n;
        end
        m_sq[i] = (m_cnt[i] < hi);
      end else begin
        m_tick[i] = 1'b0;
        m_half[i] = 1'b0;
      end
    end
  endfunction

  task automatic check_model();
    for (int i = 0; i < 3; i++) begin
      logic [2:0] exp_v;
      exp_v = {m_tick[i], m_sq[i], m_half[i]};
      n_checks++;
      if (dut_out[i] !== exp_v) begin
        n_fail++;
        $display("FAIL model_dut%0d t=%0t got tick/sq/half=%b expected %b", i, $time, dut_out[i], exp_v);
      end
    end
  endtask

  // One clock: apply inputs, let the edge pass, update the model, sample 2 ns after the edge.
  task automatic drive(logic r, logic e, logic c, logic f);
    rst = r; en = e; clr = c; fast = f;
    @(posedge clk);
    model_edge(r, e, c, f);
    #2;
    check_model();
  endtask

  typedef struct {
    logic r, e, c, f;
    logic t, s, h;
  } vec_t;
  vec_t tbl [$];

  function automatic void add(logic r, logic e, logic c, logic f, logic t, logic s, logic h);
    vec_t v;
    v.r = r; v.e = e; v.c = c; v.f = f; v.t = t; v.s = s; v.h = h;
    tbl.push_back(v);
  endfunction

  task automatic add_period();
    repeat (4) add(0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 1);
    repeat (4) add(0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 1, 1);
  endtask

  logic [2:0] exp_q [$];

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; fast = 1'b0;
    model_cfg(0, 10, 1, 4);
    model_cfg(1, 7, 1, 3);
    model_cfg(2, 10, 3, 2);

    // Vector table for the 10:1 instance
    add(1, 0, 0, 0, 0, 1, 0);
    add_period();
    repeat (4) add(0, 1, 0, 0, 0, 1, 0);
    repeat (3) add(0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 1);
    repeat (4) add(0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 1, 1);
    repeat (4) add(0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 1);
    repeat (2) add(0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 1, 0);
    add_period();
    repeat (4) add(0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 1);
    repeat (4) add(0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 1, 0);
    repeat (2) add(0, 1, 0, 0, 0, 1, 0);
    add(1, 1, 1, 0, 0, 1, 0);
    add(0, 1, 0, 1, 0, 1, 0);
    add(0, 1, 0, 1, 0, 0, 1);
    add(0, 1, 0, 1, 1, 1, 1);
    add(0, 1, 1, 0, 0, 1, 0);
    add(0, 1, 0, 1, 0, 1, 0);
    add(0, 1, 0, 1, 0, 0, 1);
    add(0, 1, 0, 1, 1, 1, 1);
    add(0, 1, 1, 0, 0, 1, 0);
    add(0, 1, 0, 1, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 1, 1, 1, 1);
    add(0, 0, 1, 0, 0, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].e, tbl[i].c, tbl[i].f);
      n_checks++;
      if ({ta, sa, ha} !== {tbl[i].t, tbl[i].s, tbl[i].h}) begin
        n_fail++;
        $display("FAIL vec%0d got tick/sq/half=%b expected %b", i, {ta, sa, ha},
                 {tbl[i].t, tbl[i].s, tbl[i].h});
      end
    end

    // Odd divisor and fractional/integer divisor of 10 by 3, continuous enable from reset
    drive(1, 0, 0, 0);
    for (int k = 1; k <= 21; k++) begin
      logic tc_exp;
`ifdef TICK_GEN_FRAC_EN
      tc_exp = ((k % 10) == 4) || ((k % 10) == 7) || ((k % 10) == 0);
`else
      tc_exp = ((k % 3) == 0);
`endif
      exp_q.push_back({((k % 7) == 0), ((k % 7) < 4), tc_exp});
    end
    for (int k = 1; k <= 21; k++) begin
      logic [2:0] exp_v;
      drive(0, 1, 0, 0);
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({tb_, sb, tc} !== exp_v) begin
        n_fail++;
        $display("FAIL seq_edge%0d got tick7/sq7/tick10_3=%b expected %b", k, {tb_, sb, tc}, exp_v);
      end
    end

    // Randomized inputs against the model
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
